ps2_key_decoder: RTL
====================

# ps2_key_decoder

Parametrised PS/2 scan-code set 2 decoder that sits between the PS/2 byte receiver (`received_data` / `received_data_en`) and user logic in the 50 MHz domain. It parses E0 (extended), F0 (break) and E1 (pause) prefix sequences, pushes decoded key events into a first-word-fall-through event FIFO, and maintains a held/toggle state bit for `NUM_KEYS` configurable keys. It generalises the fixed four-LED keyboard-to-LED path to any key count, adds buffering, and defines break-code semantics.

## Interface
- `NUM_KEYS`, 4: number of tracked keys; `key_state` width.
- `KEY_CODES`, {9'h023, 9'h01B, 9'h01C, 9'h01D}: packed 9 bits per key, {ext, code}; key 0 is in the LSBs (default key0=1D, key1=1C, key2=1B, key3=23).
- `LED_MODE`, 0: 0 = held (1 while pressed), 1 = toggle on each fresh press.
- `FIFO_DEPTH`, 8: event FIFO depth; power of two, ≥2.
- `TIMEOUT_CYC`, 2_500_000: idle cycles after which a partial prefix sequence is abandoned (50 ms at 50 MHz).

Ports:
- `CLK` in 1: 50 MHz clock.
- `RST` in 1: asynchronous, active-high reset.
- `rx_data` in 8: byte from the PS/2 receiver.
- `rx_en` in 1: one-cycle strobe; `rx_data` is valid when high.
- `evt_rd` in 1: pop the head event.
- `evt_valid` out 1: FIFO is not empty.
- `evt_code` out 8: head event scan code.
- `evt_ext` out 1: head event was E0-prefixed.
- `evt_break` out 1: head event is a release.
- `evt_overflow` out 1: sticky; an event was dropped while the FIFO was full.
- `fifo_count` out clog2(FIFO_DEPTH)+1: number of entries.
- `key_state` out NUM_KEYS: per-key state.

## Operation
- Parser FSM states and transitions on each `rx_en`:
  - IDLE: E0→EXT; F0→BRK; E1→SKIP with cnt=7; 00/AA/FA/FE/FF are discarded; any other byte emits make{ext=0}.
  - EXT: F0→EXT_BRK; E0→EXT; any other byte emits make{ext=1}, then →IDLE.
  - BRK: F0→BRK; E0→EXT_BRK; any other byte emits break{ext=0}, then →IDLE.
  - EXT_BRK: F0/E0→stay; any other byte emits break{ext=1}, then →IDLE.
  - SKIP: decrement cnt on each byte; →IDLE after the 7th byte; no event is emitted.
- Timeout: in any non-IDLE state, an idle counter reaching TIMEOUT_CYC forces →IDLE with no event. The counter resets on each `rx_en` and in IDLE.
- Emit: the FIFO pushes {ext, break, code}.
  - Full FIFO with no pop in the same cycle: the event is dropped and `evt_overflow` is set. It stays set until `RST`.
  - Full FIFO with `evt_rd` in the same cycle: pop and push both occur; count is unchanged; no overflow.
  - `evt_rd` while empty is ignored.
- Key tracking is independent of FIFO fullness. It matches {ext, code} against each KEY_CODES entry.
  - Internal `held[i]`: set on make, cleared on break.
  - LED_MODE 0: `key_state[i]` = `held[i]`.
  - LED_MODE 1: `key_state[i]` toggles on a make only when `held[i]` was 0, so typematic repeats do not toggle. A break never toggles.
  - Duplicate KEY_CODES entries update all matching bits.
- Reset values: FSM=IDLE, FIFO empty, `evt_valid`=0, `evt_code`/`evt_ext`/`evt_break`=0, `evt_overflow`=0, `fifo_count`=0, `key_state`=0, `held`=0.
  - A reset mid-sequence discards the partial prefix.

## Timing
- `rx_en` high at cycle n with a final byte:
  - FIFO entry and `key_state` update are visible at n+1.
  - `evt_valid` rises at n+1 if the FIFO was empty.
- `rx_en` is accepted every cycle; back-to-back bytes are legal.
- `evt_rd` at cycle n with `evt_valid`=1: the next head (or `evt_valid`=0) appears at n+1.
- FWFT: `evt_code`/`evt_ext`/`evt_break` are valid whenever `evt_valid`=1 and hold stable until popped.
- All outputs are registered.

## Structure
- Package `ps2_kbd_pkg`:
  - Constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_BAT_OK=8'hAA, PS2_ACK=8'hFA, PS2_RESEND=8'hFE.
  - Parser state enum {IDLE, EXT, BRK, EXT_BRK, SKIP}.
  - 10-bit event type.
- Sub-module `ps2_event_fifo`: parametrised-depth FWFT FIFO with simultaneous push/pop and count output.
- The parser, timeout counter and key tracker live in the top module.

## Test plan
- Bytes 1D, F0 1D, LED_MODE 0: events {0,0,1D}, {0,1,1D}; `key_state[0]` is 1 after the first byte and 0 after F0 1D.
- Bytes E0 75, E0 F0 75: events {1,0,75}, {1,1,75}; `key_state` stays 0 (no match). Then bytes AA, FA: no events.
- LED_MODE 1, bytes 1C 1C 1C F0 1C 1C: `key_state[1]` reads 1 after the first 1C, stays 1 through the repeats and the break, then reads 0 after the final 1C.
- FIFO_DEPTH 8, ten make codes with no reads: `fifo_count`=8, `evt_overflow`=1. Popping returns the first 8 codes in order. Then `evt_valid`=0, and `evt_overflow` stays 1.
- Byte E0, then idle for TIMEOUT_CYC cycles, then byte 1D: event {0,0,1D}, not extended. Separately, bytes E1 14 77 E1 F0 14 F0 77 produce no events.
- Byte F0, then `RST` pulse mid-sequence, then byte 1B: event {0,0,1B} (a make, not a break); `key_state[2]`=1.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// Shared constants, parser state and event types for the PS/2 set-2 key decoder.
package ps2_kbd_pkg;

  localparam logic [7:0] PS2_EXT     = 8'hE0;
  localparam logic [7:0] PS2_BRK     = 8'hF0;
  localparam logic [7:0] PS2_PAUSE   = 8'hE1;
  localparam logic [7:0] PS2_BAT_OK  = 8'hAA;
  localparam logic [7:0] PS2_ACK     = 8'hFA;
  localparam logic [7:0] PS2_RESEND  = 8'hFE;
  localparam logic [7:0] PS2_ERR_LO  = 8'h00;
  localparam logic [7:0] PS2_ERR_HI  = 8'hFF;

  // Bytes that follow the E1 of the Pause key and are swallowed without an event.
  localparam int PS2_PAUSE_LEN = 7;

  typedef logic [2:0] skip_cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    SKIP
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  function automatic logic ps2_is_prefix(input logic [7:0] b);
    return (b == PS2_EXT) || (b == PS2_BRK);
  endfunction

  // Controller chatter and error bytes that never denote a key.
  function automatic logic ps2_is_noise(input logic [7:0] b);
    return (b == PS2_ERR_LO) || (b == PS2_BAT_OK) || (b == PS2_ACK) ||
           (b == PS2_RESEND) || (b == PS2_ERR_HI);
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Byte-in / event-out bundle between the PS/2 receiver side, the decoder and user logic.
interface ps2_key_decoder_if #(
  parameter int NUM_KEYS   = 4,
  parameter int FIFO_DEPTH = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]          rx_data;
  logic                rx_en;
  logic                evt_rd;
  logic                evt_valid;
  logic [7:0]          evt_code;
  logic                evt_ext;
  logic                evt_break;
  logic                evt_overflow;
  logic [CNT_W-1:0]    fifo_count;
  logic [NUM_KEYS-1:0] key_state;

  modport master (
    output rx_data, rx_en, evt_rd,
    input  evt_valid, evt_code, evt_ext, evt_break, evt_overflow, fifo_count, key_state
  );

  modport slave (
    input  rx_data, rx_en, evt_rd,
    output evt_valid, evt_code, evt_ext, evt_break, evt_overflow, fifo_count, key_state
  );
endinterface

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO built as a shift register so the head entry is
// itself a flop; supports push and pop in the same cycle and a sticky overflow flag.
module ps2_event_fifo
  import ps2_kbd_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  ps2_evt_t         wdata,
  input  logic             pop,
  output logic             valid,
  output ps2_evt_t         head,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  ps2_evt_t         mem_q [DEPTH];
  ps2_evt_t         mem_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  logic             full;
  logic             do_pop;
  logic             do_push;
  logic [CNT_W-1:0] wr_idx;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    mem_d   = mem_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    full    = (count_q == CNT_W'(DEPTH));
    do_pop  = pop && (count_q != '0);
    do_push = push && (!full || do_pop);
    wr_idx  = do_pop ? (count_q - CNT_W'(1)) : count_q;

    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      mem_d[DEPTH-1] = '0;
    end

    if (do_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == wr_idx) begin
          mem_d[i] = wdata;
        end
      end
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (push && full && !do_pop) begin
      ovf_d = 1'b1;
    end

    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the storage is reset because entry 0 drives the head outputs, which must read 0 out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
      mem_q   <= mem_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid    = valid_q;
  assign head     = mem_q[0];
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 decoder: prefix parser with idle timeout, buffered key events
// and a held/toggle state bit for each configured key.
module ps2_key_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int                      NUM_KEYS    = 4,
  parameter logic [9*NUM_KEYS-1:0]   KEY_CODES   = {9'h023, 9'h01B, 9'h01C, 9'h01D},
  parameter int                      LED_MODE    = 0,
  parameter int                      FIFO_DEPTH  = 8,
  parameter int                      TIMEOUT_CYC = 2_500_000
) (
  input  logic               CLK,
  input  logic               RST,
  ps2_key_decoder_if.slave   bus
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  ps2_state_e        state_q, state_d;
  skip_cnt_t         skip_q, skip_d;
  logic [TO_W-1:0]   idle_q, idle_d;

  logic              emit;
  ps2_evt_t          evt;
  ps2_evt_t          head;

  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [NUM_KEYS-1:0] tog_q, tog_d;

  // Parser state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      skip_q  <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      idle_q  <= idle_d;
    end
  end

  // Next-state: byte-driven transitions, or the idle timeout while a prefix is pending.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    idle_d  = '0;

    if (bus.rx_en) begin
      case (state_q)
        IDLE: begin
          if (bus.rx_data == PS2_EXT) begin
            state_d = EXT;
          end else if (bus.rx_data == PS2_BRK) begin
            state_d = BRK;
          end else if (bus.rx_data == PS2_PAUSE) begin
            state_d = SKIP;
            skip_d  = skip_cnt_t'(PS2_PAUSE_LEN);
          end
        end
        EXT: begin
          if (bus.rx_data == PS2_BRK)      state_d = EXT_BRK;
          else if (bus.rx_data == PS2_EXT) state_d = EXT;
          else                             state_d = IDLE;
        end
        BRK: begin
          if (bus.rx_data == PS2_BRK)      state_d = BRK;
          else if (bus.rx_data == PS2_EXT) state_d = EXT_BRK;
          else                             state_d = IDLE;
        end
        EXT_BRK: begin
          if (!ps2_is_prefix(bus.rx_data)) state_d = IDLE;
        end
        SKIP: begin
          skip_d = skip_q - skip_cnt_t'(1);
          if (skip_q == skip_cnt_t'(1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (idle_q == TO_W'(TIMEOUT_CYC - 1)) begin
        state_d = IDLE;
      end else begin
        idle_d = idle_q + TO_W'(1);
      end
    end
  end

  // Output decode: a final (non-prefix) byte emits an event flavoured by the pending prefixes.
  always_comb begin
    emit     = 1'b0;
    evt.ext  = (state_q == EXT) || (state_q == EXT_BRK);
    evt.brk  = (state_q == BRK) || (state_q == EXT_BRK);
    evt.code = bus.rx_data;

    if (bus.rx_en) begin
      case (state_q)
        IDLE:             emit = !ps2_is_prefix(bus.rx_data) &&
                                 (bus.rx_data != PS2_PAUSE) &&
                                 !ps2_is_noise(bus.rx_data);
        EXT, BRK, EXT_BRK: emit = !ps2_is_prefix(bus.rx_data);
        default:          emit = 1'b0;
      endcase
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (emit),
    .wdata    (evt),
    .pop      (bus.evt_rd),
    .valid    (bus.evt_valid),
    .head     (head),
    .count    (bus.fifo_count),
    .overflow (bus.evt_overflow)
  );

  assign bus.evt_code  = head.code;
  assign bus.evt_ext   = head.ext;
  assign bus.evt_break = head.brk;

  // Key tracker sees every decoded event, even ones the FIFO had to drop.
  always_comb begin
    held_d = held_q;
    tog_d  = tog_q;
    if (emit) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (KEY_CODES[9*i +: 9] == {evt.ext, evt.code}) begin
          if (evt.brk) begin
            held_d[i] = 1'b0;
          end else begin
            if (!held_q[i]) tog_d[i] = ~tog_q[i];
            held_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      held_q <= '0;
      tog_q  <= '0;
    end else begin
      held_q <= held_d;
      tog_q  <= tog_d;
    end
  end

  assign bus.key_state = (LED_MODE != 0) ? tog_q : held_q;

endmodule
